fifo_sync_top: RTL and testbench
================================

# fifo_sync_top

Single-clock, parametrised FIFO for the PCS TX datapath: the next generation of the dual-port FIFO memory, with pointer management, status flags and an occupancy count built in. It buffers DATASIZE-bit words, by default 264-bit PCS blocks, between TX pipeline stages that run on one clock but stall independently. It adds programmable almost-full/almost-empty thresholds, a registered read port with a valid strobe, and sticky overflow/underflow error flags.

## Interface
- DATASIZE, 264, word width in bits
- ADDRSIZE, 5, address bits; DEPTH = 1<<ADDRSIZE words (32)
- AFULL_LEVEL, DEPTH-4, walmost_full asserts when count >= AFULL_LEVEL
- AEMPTY_LEVEL, 4, ralmost_empty asserts when count <= AEMPTY_LEVEL

- wclk  in  1  sole clock; all state updates on the rising edge
- wrst  in  1  asynchronous, active-high reset
- winc  in  1  write request
- wdata  in  DATASIZE  write data, sampled when a write is accepted
- rinc  in  1  read request
- err_clr  in  1  synchronous clear of overflow and underflow
- rdata  out  DATASIZE  registered read data
- rvalid  out  1  rdata was loaded by a read accepted on the previous edge
- wfull  out  1  count == DEPTH
- rempty  out  1  count == 0
- walmost_full  out  1  count >= AFULL_LEVEL
- ralmost_empty  out  1  count <= AEMPTY_LEVEL
- count  out  ADDRSIZE+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- **Pointers:** wptr and rptr are each ADDRSIZE+1 bits.
  - The low ADDRSIZE bits address the memory; the MSB is the wrap bit.
  - Each pointer increments by 1 per accepted operation and wraps naturally at 2*DEPTH.
- **Read acceptance:** rd_ok = rinc && !rempty.
- **Write acceptance:** wr_ok = winc && (!wfull || rd_ok). A write to a full FIFO is accepted only when a read is accepted in the same cycle.
- **Empty FIFO:** with rinc and winc both high, the read is rejected (underflow sets) and the write is accepted. There is no write-through.
- **Write:** on wr_ok, mem[wptr[ADDRSIZE-1:0]] <= wdata and wptr increments.
- **Read:** on rd_ok, rdata <= mem[rptr[ADDRSIZE-1:0]] and rptr increments. With no accepted read, rdata holds its value.
- **Count update:** count <= count + wr_ok - rd_ok. It never exceeds DEPTH and never goes below 0.
- **Flags:** all four status flags are decoded from the registered count. There is no combinational path from winc or rinc to any flag.
- **Error flags:**
  - overflow sets on winc && !wr_ok; underflow sets on rinc && !rd_ok.
  - Both hold until err_clr or wrst.
  - If err_clr and a new error occur in the same cycle, the flag stays set.
- **Memory:** storage is not reset. Contents are undefined until written.
- **Parameter rules:** the bench checks, and a generate-time $error fires on violation, that AEMPTY_LEVEL < AFULL_LEVEL <= DEPTH.

## Timing
- **Reset values:** while wrst is high, and immediately on its assertion:
  - wptr = rptr = 0, count = 0
  - rdata = 0, rvalid = 0
  - rempty = 1, wfull = 0, walmost_full = 0, ralmost_empty = 1
  - overflow = underflow = 0
- **Reset release:** wrst is deasserted synchronously to wclk externally. The first accepted operation occurs on the first edge after release.
- **Reset mid-operation:** in-flight words are discarded, pointers and count return to 0, and rvalid drops immediately.
- **Write-to-read latency:** a word written on edge N is counted at N, so rempty falls after edge N. It can be read at edge N+1, and rdata/rvalid are valid after edge N+1.
- **Read latency:** 1 cycle. rvalid is high for exactly the cycle following each accepted read.
- **Flag timing:** every flag reflects the state after the most recent edge.
  - wfull rises in the cycle after the DEPTH-th write.
  - rempty rises in the cycle after the last read.
- **Throughput:** one write and one read per cycle, sustained, at any occupancy 1..DEPTH-1.

## Test plan
- **Fill and overflow:** reset, then write 0x1..0x20 on 32 consecutive cycles, then one more write of 0x21.
  - count = 32, wfull = 1 and walmost_full = 1 (count >= 28).
  - overflow = 1; 0x21 is not stored.
  - err_clr for one cycle clears overflow.
- **Drain, order and latency:** from the full state, rinc high for 33 cycles.
  - rdata = 0x1..0x20 in order, each with rvalid one cycle after its read.
  - After the 32nd read, rempty = 1; the 33rd read sets underflow.
  - rdata holds 0x20.
- **Simultaneous at full:** at count = 32, winc and rinc high for one cycle with wdata = 0xAA.
  - count stays 32, no overflow, and 0xAA is read out last.
- **Simultaneous at empty:** at count = 0, winc and rinc high with wdata = 0x55.
  - underflow = 1, count = 1, rvalid = 0.
  - A read on the next cycle returns 0x55.
- **Wrap-around and thresholds:** stream 200 words with random winc/rinc, occupancy kept between 0 and 32.
  - Output matches a scoreboard; pointers cross 2*DEPTH several times.
  - ralmost_empty and walmost_full match count <= 4 and count >= 28 every cycle.
- **Reset mid-operation:** at count = 17, with a read accepted on the previous edge, pulse wrst high asynchronously between edges.
  - Outputs take reset values without waiting for an edge: count = 0, rempty = 1, rvalid = 0, rdata = 0.
  - The next write/read pair returns the new data.

Source files
------------

// File: rtl/fifo_sync_top_if.sv
// fifo_sync_top_if: write/read handshake, data and status bundle of the synchronous FIFO
interface fifo_sync_top_if #(
  parameter int DATASIZE = 264,
  parameter int ADDRSIZE = 5
);
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                rinc;
  logic                err_clr;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                wfull;
  logic                rempty;
  logic                walmost_full;
  logic                ralmost_empty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;
  modport master (
    output winc, wdata, rinc, err_clr,
    input  rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
  );
  modport slave (
    input  winc, wdata, rinc, err_clr,
    output rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_top.sv
// fifo_sync_top: single-clock FIFO with registered read port, threshold flags and sticky errors
module fifo_sync_top #(
  parameter int DATASIZE     = 264,
  parameter int ADDRSIZE     = 5,
  parameter int AFULL_LEVEL  = (1 << ADDRSIZE) - 4,
  parameter int AEMPTY_LEVEL = 4
) (
  input logic            wclk,
  input logic            wrst,
  fifo_sync_top_if.slave bus
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] L_DEPTH  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] L_AFULL  = (ADDRSIZE+1)'(AFULL_LEVEL);
  localparam logic [ADDRSIZE:0] L_AEMPTY = (ADDRSIZE+1)'(AEMPTY_LEVEL);
  localparam logic [ADDRSIZE:0] L_ONE    = (ADDRSIZE+1)'(1);
  generate
    if (!(AEMPTY_LEVEL < AFULL_LEVEL && AFULL_LEVEL <= DEPTH)) begin : g_bad_levels
      $error("fifo_sync_top: need AEMPTY_LEVEL < AFULL_LEVEL <= DEPTH");
    end
  endgenerate
  logic [DATASIZE-1:0] r_mem [DEPTH];
  logic [ADDRSIZE:0]   r_wptr;
  logic [ADDRSIZE:0]   r_rptr;
  logic [ADDRSIZE:0]   r_count;
  logic [DATASIZE-1:0] r_rdata;
  logic                r_rvalid;
  logic                r_overflow;
  logic                r_underflow;
  logic                w_rd_ok;
  logic                w_wr_ok;
  // a full FIFO still takes a write when a read frees a slot on the same edge
  assign w_rd_ok = bus.rinc && r_count != '0;
  assign w_wr_ok = bus.winc && (r_count != L_DEPTH || w_rd_ok);
  always_ff @(posedge wclk)
    if (w_wr_ok) r_mem[r_wptr[ADDRSIZE-1:0]] <= bus.wdata;
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + L_ONE;
      if (w_rd_ok) begin
        r_rptr  <= r_rptr + L_ONE;
        r_rdata <= r_mem[r_rptr[ADDRSIZE-1:0]];
      end
      r_count     <= r_count + (ADDRSIZE+1)'(w_wr_ok) - (ADDRSIZE+1)'(w_rd_ok);
      r_rvalid    <= w_rd_ok;
      r_overflow  <= (r_overflow && !bus.err_clr) || (bus.winc && !w_wr_ok);
      r_underflow <= (r_underflow && !bus.err_clr) || (bus.rinc && !w_rd_ok);
    end
  assign bus.rdata         = r_rdata;
  assign bus.rvalid        = r_rvalid;
  assign bus.count         = r_count;
  assign bus.wfull         = r_count == L_DEPTH;
  assign bus.rempty        = r_count == '0;
  assign bus.walmost_full  = r_count >= L_AFULL;
  assign bus.ralmost_empty = r_count <= L_AEMPTY;
  assign bus.overflow      = r_overflow;
  assign bus.underflow     = r_underflow;
endmodule

// File: tb/tb_fifo_sync_top.sv
// tb_fifo_sync_top: vector table, corner sequences and random traffic against a queue model
module tb_fifo_sync_top;
  localparam int DW = 264;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  typedef logic [DW-1:0] word_t;
  typedef struct {
    logic       wi;
    logic       ri;
    logic       cl;
    logic [7:0] wd;
    int         ecount;
    logic       erv;
    logic [7:0] erd;
    logic       eun;
  } vec_t;
  logic wclk = 1'b0;
  logic wrst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  word_t q[$];
  word_t m_rdata = '0;
  logic m_rvalid = 1'b0;
  logic m_ov = 1'b0;
  logic m_un = 1'b0;
  fifo_sync_top_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();
  fifo_sync_top #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (.wclk(wclk), .wrst(wrst), .bus(bus));
  always #5 wclk = ~wclk;
  task automatic chk(input string name, input word_t act, input word_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_model();
    chk("count", DW'(bus.count), DW'(q.size()));
    chk("rempty", DW'(bus.rempty), DW'(q.size() == 0));
    chk("wfull", DW'(bus.wfull), DW'(q.size() == DEPTH));
    chk("walmost_full", DW'(bus.walmost_full), DW'(q.size() >= DEPTH - 4));
    chk("ralmost_empty", DW'(bus.ralmost_empty), DW'(q.size() <= 4));
    chk("rvalid", DW'(bus.rvalid), DW'(m_rvalid));
    chk("rdata", bus.rdata, m_rdata);
    chk("overflow", DW'(bus.overflow), DW'(m_ov));
    chk("underflow", DW'(bus.underflow), DW'(m_un));
  endtask
  task automatic model_reset();
    q.delete();
    m_rdata = '0;
    m_rvalid = 1'b0;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask
  task automatic cyc(input logic wi, input logic ri, input logic cl, input word_t wd);
    logic rd_ok, wr_ok;
    bus.winc = wi;
    bus.rinc = ri;
    bus.err_clr = cl;
    bus.wdata = wd;
    @(posedge wclk);
    rd_ok = ri && q.size() > 0;
    wr_ok = wi && (q.size() < DEPTH || rd_ok);
    if (rd_ok) m_rdata = q.pop_front();
    if (wr_ok) q.push_back(wd);
    m_rvalid = rd_ok;
    m_ov = (m_ov && !cl) || (wi && !wr_ok);
    m_un = (m_un && !cl) || (ri && !rd_ok);
    #1;
    check_model();
  endtask
  task automatic do_reset();
    wrst = 1'b1;
    model_reset();
    #1;
    check_model();
    @(negedge wclk);
    wrst = 1'b0;
  endtask
  function automatic word_t rnd_word();
    word_t w = '0;
    for (int i = 0; i < 9; i++) w = {w[DW-33:0], 32'($urandom())};
    return w;
  endfunction
  initial begin
    vec_t vt[12];
    int written, cycles;
    logic wi, ri;
    vt[0]  = '{1, 0, 0, 8'h11, 1, 0, 8'h00, 0};
    vt[1]  = '{1, 0, 0, 8'h22, 2, 0, 8'h00, 0};
    vt[2]  = '{1, 1, 0, 8'h33, 2, 1, 8'h11, 0};
    vt[3]  = '{0, 1, 0, 8'h00, 1, 1, 8'h22, 0};
    vt[4]  = '{0, 1, 0, 8'h00, 0, 1, 8'h33, 0};
    vt[5]  = '{0, 1, 0, 8'h00, 0, 0, 8'h33, 1};
    vt[6]  = '{0, 0, 1, 8'h00, 0, 0, 8'h33, 0};
    vt[7]  = '{0, 1, 1, 8'h00, 0, 0, 8'h33, 1};
    vt[8]  = '{0, 0, 1, 8'h00, 0, 0, 8'h33, 0};
    vt[9]  = '{1, 1, 0, 8'h44, 1, 0, 8'h33, 1};
    vt[10] = '{0, 1, 0, 8'h00, 0, 1, 8'h44, 1};
    vt[11] = '{0, 0, 1, 8'h00, 0, 0, 8'h44, 0};
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    bus.err_clr = 1'b0;
    bus.wdata = '0;
    #12;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].wi, vt[i].ri, vt[i].cl, DW'(vt[i].wd));
      chk($sformatf("vec%0d count", i), DW'(bus.count), DW'(vt[i].ecount));
      chk($sformatf("vec%0d rvalid", i), DW'(bus.rvalid), DW'(vt[i].erv));
      chk($sformatf("vec%0d rdata", i), bus.rdata, DW'(vt[i].erd));
      chk($sformatf("vec%0d underflow", i), DW'(bus.underflow), DW'(vt[i].eun));
    end
    do_reset();
    for (int i = 1; i <= 32; i++) cyc(1, 0, 0, DW'(i));
    chk("fill count", DW'(bus.count), DW'(32));
    chk("fill wfull", DW'(bus.wfull), DW'(1));
    chk("fill walmost_full", DW'(bus.walmost_full), DW'(1));
    cyc(1, 0, 0, DW'(8'h21));
    chk("extra write overflow", DW'(bus.overflow), DW'(1));
    chk("extra write count", DW'(bus.count), DW'(32));
    cyc(0, 0, 1, '0);
    chk("err_clr overflow", DW'(bus.overflow), DW'(0));
    for (int i = 1; i <= 33; i++) begin
      cyc(0, 1, 0, '0);
      if (i <= 32) begin
        chk($sformatf("drain rdata %0d", i), bus.rdata, DW'(i));
        chk($sformatf("drain rvalid %0d", i), DW'(bus.rvalid), DW'(1));
      end else begin
        chk("drain extra underflow", DW'(bus.underflow), DW'(1));
        chk("drain extra rvalid", DW'(bus.rvalid), DW'(0));
        chk("drain rdata hold", bus.rdata, DW'(8'h20));
      end
      if (i == 32) chk("drain rempty", DW'(bus.rempty), DW'(1));
    end
    cyc(0, 0, 1, '0);
    for (int i = 1; i <= 32; i++) cyc(1, 0, 0, DW'(i + 256));
    cyc(1, 1, 0, DW'(8'hAA));
    chk("full rw count", DW'(bus.count), DW'(32));
    chk("full rw overflow", DW'(bus.overflow), DW'(0));
    chk("full rw rdata", bus.rdata, DW'(257));
    for (int i = 0; i < 32; i++) cyc(0, 1, 0, '0);
    chk("full rw last word", bus.rdata, DW'(8'hAA));
    cyc(1, 1, 0, DW'(8'h55));
    chk("empty rw underflow", DW'(bus.underflow), DW'(1));
    chk("empty rw count", DW'(bus.count), DW'(1));
    chk("empty rw rvalid", DW'(bus.rvalid), DW'(0));
    cyc(0, 1, 1, '0);
    chk("empty rw readback", bus.rdata, DW'(8'h55));
    written = 0;
    cycles = 0;
    while (written < 200 && cycles < 3000) begin
      wi = ($urandom_range(0, 99) < (((cycles / 40) % 2 == 0) ? 70 : 30));
      ri = ($urandom_range(0, 99) < (((cycles / 40) % 2 == 0) ? 30 : 70));
      if (wi && (q.size() < DEPTH || (ri && q.size() > 0))) written++;
      cyc(wi, ri, $urandom_range(0, 7) == 0, rnd_word());
      cycles++;
    end
    chk("random stream complete", DW'(written), DW'(200));
    do_reset();
    for (int i = 0; i < 18; i++) cyc(1, 0, 0, DW'(i + 8'h60));
    cyc(0, 1, 0, '0);
    chk("pre-reset count", DW'(bus.count), DW'(17));
    chk("pre-reset rvalid", DW'(bus.rvalid), DW'(1));
    #2;
    wrst = 1'b1;
    #1;
    chk("async reset count", DW'(bus.count), DW'(0));
    chk("async reset rempty", DW'(bus.rempty), DW'(1));
    chk("async reset rvalid", DW'(bus.rvalid), DW'(0));
    chk("async reset rdata", bus.rdata, DW'(0));
    model_reset();
    @(negedge wclk);
    wrst = 1'b0;
    cyc(1, 0, 0, DW'(8'h77));
    cyc(0, 1, 0, '0);
    chk("post-reset readback", bus.rdata, DW'(8'h77));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
